// File: rtl/flag_pkg.sv
// Shared flag-bit positions, condition-code encodings and the condition evaluator
// used by the flag/condition unit.
package flag_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    function automatic logic cond_eval(input logic [3:0] status, input logic [3:0] code);
        logic c, z, v, n, r;
        c = status[FLAG_C];
        z = status[FLAG_Z];
        v = status[FLAG_V];
        n = status[FLAG_N];
        case (code)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// Parameterised LIFO for status words; illegal operations leave it untouched
// and raise a sticky error until reset.
module flag_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (do_push) begin
                count <= count + CW'(1);
            end else if (do_pop) begin
                count <= count - CW'(1);
            end
            if ((push & pop) | (push & full) | (pop & empty)) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (CW'(i) == count)) begin
                mem[i] <= din;
            end
        end
    end

    // Top of stack is the entry just below the count.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count) begin
                dout = mem[i];
            end
        end
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Status register with save/restore stack and a registered condition evaluator
// behind a ready/valid handshake with a one-entry skid.
module flag_cond_unit
    import flag_pkg::*;
#(
    parameter int         STACK_DEPTH  = 4,
    parameter logic [3:0] RESET_STATUS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    input  logic       carry_in,
    input  logic       zero_in,
    input  logic       overflow_in,
    input  logic       negative_in,
    input  logic       wr_en,
    input  logic [3:0] wr_data,
    input  logic       push,
    input  logic       pop,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       res_valid,
    output logic       res_taken,
    input  logic       res_ready,
    output logic [3:0] status,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       stack_err
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [3:0]    stack_top;
    logic [CW-1:0] stack_count;
    logic          valid_pop;
    logic [3:0]    alu_flags;
    logic [3:0]    next_status;
    logic          accept;

    flag_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (4),
        .CW    (CW)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (status),
        .dout  (stack_top),
        .count (stack_count),
        .full  (stack_full),
        .empty (stack_empty),
        .err   (stack_err)
    );

    assign valid_pop  = pop & ~push & (stack_count != '0);
    assign cond_ready = ~res_valid | res_ready;
    assign accept     = cond_valid & cond_ready;

    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_C] = carry_in;
        alu_flags[FLAG_Z] = zero_in;
        alu_flags[FLAG_V] = overflow_in;
        alu_flags[FLAG_N] = negative_in;
    end

    // A restore from the stack outranks direct loads, which outrank ALU capture.
    always_comb begin
        next_status = status;
        if (valid_pop) begin
            next_status = stack_top;
        end else if (wr_en) begin
            next_status = wr_data;
        end else if (alu_valid) begin
            next_status = alu_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status <= RESET_STATUS;
        end else begin
            status <= next_status;
        end
    end

    // Evaluating against next_status forwards same-cycle flag updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_taken <= 1'b0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_taken <= cond_eval(next_status, cond_code);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
